ex_muldiv: RTL and testbench

- Multi-cycle RV32M multiply/divide unit in the Execute stage.
- Consumes operands and funct3 from the ID/EX register outputs.
- While computing, it asserts a stall request that holds the ID/EX register and all upstream stages.
- Presents a one-cycle-valid result for the EX/MEM path; the ALU result is muxed out whenever an M-type instruction is in EX.

---
 rtl/ex_muldiv_pkg.sv | 20 ++
 rtl/ex_muldiv_if.sv | 25 ++
 rtl/ex_muldiv_core.sv | 75 +++++++
 rtl/ex_muldiv.sv | 131 +++++++++++++
 tb/tb_ex_muldiv.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared constants and types for the RV32M multiply/divide unit in EX.
package ex_muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

endpackage

// File: rtl/ex_muldiv_if.sv
// Handshake between the EX stage pipeline and the mul/div unit.
interface ex_muldiv_if
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
);
  logic             flush;
  logic             in_valid;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             stall_req;
  logic             result_valid;
  logic [WIDTH-1:0] result;

  modport master (
    output flush, in_valid, funct3, op_a, op_b,
    input  stall_req, result_valid, result
  );

  modport slave (
    input  flush, in_valid, funct3, op_a, op_b,
    output stall_req, result_valid, result
  );
endinterface

// File: rtl/ex_muldiv_core.sv
// Iterative datapath: radix-2 shift-add multiply and restoring divide on
// unsigned magnitudes. hi/lo hold {product_hi, product_lo} for multiply and
// {remainder, quotient} for divide. The next-step values are exported so the
// owner can capture the final result on the same edge as the last step.
module ex_muldiv_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_abs,
  input  logic [WIDTH-1:0] b_abs,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next,
  output logic             last
);

  logic [WIDTH-1:0] hi, lo, mcand;
  logic             div_q;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // One iteration: add-and-shift-right for multiply, shift-and-subtract for divide.
  always_comb begin
    addend  = lo[0] ? mcand : '0;
    sum     = {1'b0, hi} + {1'b0, addend};
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - mcand;
    hi_next = hi;
    lo_next = lo;
    if (div_q) begin
      if (shifted >= {1'b0, mcand}) begin
        hi_next = diff;
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = shifted[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_next = sum[WIDTH:1];
      lo_next = {sum[0], lo[WIDTH-1:1]};
    end
  end

  // Load operands on start, advance one step per cycle while stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      div_q <= 1'b0;
      cnt   <= '0;
    end else if (start) begin
      hi    <= '0;
      lo    <= is_div ? a_abs : b_abs;
      mcand <= is_div ? b_abs : a_abs;
      div_q <= is_div;
      cnt   <= '0;
    end else if (step) begin
      hi    <= hi_next;
      lo    <= lo_next;
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit for the Execute stage. Owns the sequencing FSM,
// divide special cases, operand sign handling and the pipeline stall.
//
//   state | meaning
//   IDLE  | waiting for an M-type instruction in EX
//   BUSY  | iterating the datapath, one step per cycle
//   DONE  | result_valid high for one cycle, stall released
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  md
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [2:0]       op_q;
  logic             sa_q, sb_q;
  logic [WIDTH-1:0] result_q;

  logic             capture, special, core_start;
  logic             sign_a_op, sign_b_op, sa, sb, is_div;
  logic             div_zero, div_ovf;
  logic [WIDTH-1:0] a_abs, b_abs, special_res;
  logic [WIDTH-1:0] hi_next, lo_next, final_res;
  logic             last;

  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quot, remv;

  assign capture    = (state == ST_IDLE) && md.in_valid && !md.flush;
  assign core_start = capture && !special;

  assign md.stall_req    = !md.flush && (capture || (state == ST_BUSY));
  assign md.result_valid = (state == ST_DONE);
  assign md.result       = result_q;

  // Operand decode: signedness, magnitudes and the results that skip iteration.
  always_comb begin
    sign_a_op = (md.funct3 == F3_MULH) || (md.funct3 == F3_MULHSU) ||
                (md.funct3 == F3_DIV)  || (md.funct3 == F3_REM);
    sign_b_op = (md.funct3 == F3_MULH) || (md.funct3 == F3_DIV) ||
                (md.funct3 == F3_REM);
    sa        = sign_a_op && md.op_a[WIDTH-1];
    sb        = sign_b_op && md.op_b[WIDTH-1];
    a_abs     = sa ? -md.op_a : md.op_a;
    b_abs     = sb ? -md.op_b : md.op_b;
    is_div    = md.funct3[2];
    div_zero  = is_div && (md.op_b == '0);
    div_ovf   = ((md.funct3 == F3_DIV) || (md.funct3 == F3_REM)) &&
                (md.op_a == INT_MIN) && (md.op_b == '1);
    special   = div_zero || div_ovf;
    // REM/REMU land on funct3[1]=1: remainder flavour of each special case.
    if (div_zero) special_res = md.funct3[1] ? md.op_a : '1;
    else          special_res = md.funct3[1] ? '0 : INT_MIN;
  end

  // Sign fix-up on the final datapath values, selected by the captured op.
  always_comb begin
    prod      = {hi_next, lo_next};
    prod_s    = (sa_q ^ sb_q) ? -prod : prod;
    quot      = (sa_q ^ sb_q) ? -lo_next : lo_next;
    remv      = sa_q ? -hi_next : hi_next;
    if (op_q[2])              final_res = op_q[1] ? remv : quot;
    else if (op_q == F3_MUL)  final_res = prod_s[WIDTH-1:0];
    else                      final_res = prod_s[2*WIDTH-1:WIDTH];
  end

  ex_muldiv_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (core_start),
    .step    (state == ST_BUSY),
    .is_div  (is_div),
    .a_abs   (a_abs),
    .b_abs   (b_abs),
    .hi_next (hi_next),
    .lo_next (lo_next),
    .last    (last)
  );

  // Sequencing FSM; flush overrides capture and completion, reset overrides all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
    end else if (md.flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (md.in_valid) begin
            op_q <= md.funct3;
            sa_q <= sa;
            sb_q <= sb;
            if (special) begin
              result_q <= special_res;
              state    <= ST_DONE;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (last) begin
            result_q <= final_res;
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed and random checks of ex_muldiv against an arithmetic reference.
module tb_ex_muldiv;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  ex_muldiv_if #(.WIDTH(W)) md ();

  ex_muldiv dut (
    .clk (clk),
    .rst (rst),
    .md  (md)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint            sa, sb, ub, p;
    longint unsigned   up;
    int                ia, ib, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    ia = $signed(a);
    ib = $signed(b);
    model = '0;
    case (f)
      3'd0: begin p = sa * sb; model = p[31:0]; end
      3'd1: begin p = sa * sb; model = p[63:32]; end
      3'd2: begin p = sa * ub; model = p[63:32]; end
      3'd3: begin up = longint'({32'h0, a}) * ub; model = up[63:32]; end
      3'd4: begin
        if (b == 0) model = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 32'h8000_0000;
        else begin q = ia / ib; model = q; end
      end
      3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) model = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 32'h0;
        else begin q = ia % ib; model = q; end
      end
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Drive an op at the current negedge (cycle C); stall must rise at once.
  task automatic issue(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    md.in_valid = 1'b1;
    md.funct3   = f;
    md.op_a     = a;
    md.op_b     = b;
    #1;
    check({tag, " stall@C"}, {63'd0, md.stall_req}, 64'd1);
  endtask

  // Wait for result_valid with a bound; stall must hold until then and drop in DONE.
  task automatic wait_result(input string tag, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int bad_stall;
    lat = -1;
    bad_stall = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (md.result_valid === 1'b1) begin
        lat = k;
        break;
      end
      if (md.stall_req !== 1'b1) bad_stall++;
    end
    check({tag, " stall_held"}, 64'(bad_stall), 64'd0);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, {32'd0, md.result}, {32'd0, exp_res});
    check({tag, " stall@done"}, {63'd0, md.stall_req}, 64'd0);
  endtask

  task automatic finish_op(input string tag);
    md.in_valid = 1'b0;
    @(negedge clk);
    check({tag, " valid_1cyc"}, {63'd0, md.result_valid}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b);
    issue(tag, f, a, b);
    wait_result(tag, model(f, a, b), latency(f, a, b));
    finish_op(tag);
  endtask

  initial begin
    int hits;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    rst = 1'b1;
    md.flush = 1'b0;
    md.in_valid = 1'b0;
    md.funct3 = '0;
    md.op_a = '0;
    md.op_b = '0;
    repeat (3) @(negedge clk);
    check("reset result", {32'd0, md.result}, 64'd0);
    check("reset valid", {63'd0, md.result_valid}, 64'd0);
    check("reset stall", {63'd0, md.stall_req}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("MUL 7x6", 3'd0, 32'd7, 32'd6);
    run_op("MULH -1x-1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002);
    run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7);
    run_op("REMU 100/7", 3'd7, 32'd100, 32'd7);
    run_op("DIVU 5/0", 3'd5, 32'd5, 32'd0);
    run_op("REMU 5/0", 3'd7, 32'd5, 32'd0);
    run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush at C+10 of a DIV, then a fresh MUL at C+12.
    issue("DIV flushed", 3'd4, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    md.flush = 1'b1;
    #1;
    check("flush stall", {63'd0, md.stall_req}, 64'd0);
    @(negedge clk);
    md.flush = 1'b0;
    md.in_valid = 1'b0;
    check("flush no_valid", {63'd0, md.result_valid}, 64'd0);
    #1;
    check("flush idle", {63'd0, md.stall_req}, 64'd0);
    @(negedge clk);
    run_op("MUL 3x3 after flush", 3'd0, 32'd3, 32'd3);

    // Reset at C+5 of a MULHU.
    issue("MULHU reset", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    md.in_valid = 1'b0;
    @(negedge clk);
    check("rst result", {32'd0, md.result}, 64'd0);
    check("rst valid", {63'd0, md.result_valid}, 64'd0);
    check("rst stall", {63'd0, md.stall_req}, 64'd0);
    rst = 1'b0;
    hits = 0;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      if (md.result_valid === 1'b1) hits++;
    end
    check("rst no_result", 64'(hits), 64'd0);

    // Back-to-back: in_valid stays high through DONE; the next op starts from IDLE.
    issue("DIVU b2b1", 3'd5, 32'd100, 32'd7);
    wait_result("DIVU b2b1", 32'd14, 33);
    @(negedge clk);
    check("b2b gap valid", {63'd0, md.result_valid}, 64'd0);
    issue("REMU b2b2", 3'd7, 32'd100, 32'd7);
    wait_result("REMU b2b2", 32'd2, 33);
    finish_op("REMU b2b2");

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 255)) - 32'd128; rb = 32'($urandom_range(1, 15)); end
        default: ;
      endcase
      run_op($sformatf("rand%0d f%0d", i, rf), rf, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
